// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_if
// Description : Signal bundle between the peripherals/CPU and irq_ctrl.
//               The slave modport is the controller; the master modport is the
//               system side that drives requests, mask writes, ack and eoi.
// Revision    : 1.0  initial release
// ============================================================================
interface irq_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    logic [NUM_SRC-1:0] src;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_din;
    logic               int_ack;
    logic               eoi;
    logic               int_req;
    logic [ID_W-1:0]    active_id;
    logic               active_valid;
    logic               spurious;
    logic [NUM_SRC-1:0] pending_out;
    logic               timeout_err;

    modport master (
        output src, mask_we, mask_din, int_ack, eoi,
        input  int_req, active_id, active_valid, spurious, pending_out, timeout_err
    );

    modport slave (
        input  src, mask_we, mask_din, int_ack, eoi,
        output int_req, active_id, active_valid, spurious, pending_out, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Edge-triggered, maskable interrupt requester for a single CPU
//               `int` line. Lowest eligible index wins; the winning ID is
//               latched on int_ack and held until eoi.
//               Optional macro IRQ_ACK_TIMEOUT_EN builds an ack-timeout
//               counter that drops int_req and sets a sticky timeout_err.
// Revision    : 1.0  initial release
// ============================================================================
module irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    irq_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic               active_valid_q, active_valid_d;
    logic               spurious_q, spurious_d;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_win_onehot;
    logic [NUM_SRC-1:0] w_clr;
    logic [ID_W-1:0]    w_win_id;
    logic               w_any;
    logic               w_tmo_hit;

    assign w_edge     = bus.src & ~src_q;
    assign w_eligible = pending_q & ~mask_q;
    assign w_any      = |w_eligible;
    // Isolate the lowest set bit: x & -x.
    assign w_win_onehot = w_eligible & (~w_eligible + {{(NUM_SRC-1){1'b0}}, 1'b1});

    // Lowest-index priority encoder over the eligible set.
    always_comb begin
        w_win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // FSM next-state and service-record updates; ack beats eoi in REQ, eoi is the
    // only exit from SERVICE so a coincident ack there is naturally ignored.
    always_comb begin
        state_d        = state_q;
        active_id_d    = active_id_q;
        active_valid_d = active_valid_q;
        spurious_d     = spurious_q;
        w_clr          = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    if (w_any) begin
                        active_id_d    = w_win_id;
                        active_valid_d = 1'b1;
                        spurious_d     = 1'b0;
                        w_clr          = w_win_onehot;
                    end else begin
                        active_valid_d = 1'b0;
                        spurious_d     = 1'b1;
                    end
                    state_d = ST_SERVICE;
                end else if (!w_any) begin
                    state_d = ST_IDLE;
                end else if (w_tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    active_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending: a new edge wins over a same-cycle clear; mask never touches pending.
    always_comb begin
        pending_d = (pending_q & ~w_clr) | w_edge;
        mask_d    = bus.mask_we ? bus.mask_din : mask_q;
    end

    // Main state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            src_q          <= '0;
            pending_q      <= '0;
            mask_q         <= '0;
            active_id_q    <= '0;
            active_valid_q <= 1'b0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= bus.src;
            pending_q      <= pending_d;
            mask_q         <= mask_d;
            active_id_q    <= active_id_d;
            active_valid_q <= active_valid_d;
            spurious_q     <= spurious_d;
        end
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    // The count equals the number of completed cycles spent in REQ.
    assign w_tmo_hit = (state_q == ST_REQ) && (tmo_cnt_q == 8'(ACK_TIMEOUT - 1));

    // Counter restarts whenever REQ is left; the error flag is sticky.
    always_comb begin
        tmo_cnt_d     = ((state_q == ST_REQ) && (state_d == ST_REQ)) ? tmo_cnt_q + 8'd1 : 8'd0;
        timeout_err_d = timeout_err_q | (w_tmo_hit && !bus.int_ack && w_any);
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q     <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    // Without the counter the limit is meaningless; REQ waits for ack forever.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg  = (ACK_TIMEOUT == 0);
    assign w_tmo_hit       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // int_req comes straight from the registered state, so it is glitch-free.
    assign bus.int_req      = (state_q == ST_REQ);
    assign bus.active_id    = active_id_q;
    assign bus.active_valid = active_valid_q;
    assign bus.spurious     = spurious_q;
    assign bus.pending_out  = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl: directed scenarios followed
//               by randomized traffic, all compared against a cycle reference
//               model of the interrupt rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 16;
`ifdef IRQ_ACK_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    irq_ctrl_if #(.NUM_SRC(N), .ID_W(IDW)) bus ();

    irq_ctrl #(.NUM_SRC(N), .ID_W(IDW), .ACK_TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 = nothing asked, 1 = asking the CPU, 2 = in ISR.
    int           m_phase;
    int           m_wait;
    logic [N-1:0] m_pend, m_mask, m_prev;
    int           m_id;
    bit           m_valid, m_spur, m_terr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_pend = '0; m_mask = '0; m_prev = '0;
        m_id = 0; m_valid = 0; m_spur = 0; m_terr = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig, edges, clr;
        int low, nphase;
        elig  = m_pend & ~m_mask;
        edges = bus.src & ~m_prev;
        clr   = '0;
        low   = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) low = i;
        nphase = m_phase;
        case (m_phase)
            0: if (low >= 0) nphase = 1;
            1: begin
                if (bus.int_ack) begin
                    if (low >= 0) begin
                        m_id = low; m_valid = 1; m_spur = 0; clr[low] = 1'b1;
                    end else begin
                        m_spur = 1; m_valid = 0;
                    end
                    nphase = 2;
                end else if (low < 0) begin
                    nphase = 0;
                end else if (TMO_ON && (m_wait + 1 >= TMO)) begin
                    m_terr = 1; nphase = 0;
                end
            end
            default: if (bus.eoi) begin m_valid = 0; nphase = 0; end
        endcase
        m_wait  = (m_phase == 1 && nphase == 1) ? m_wait + 1 : 0;
        m_pend  = (m_pend & ~clr) | edges;
        m_prev  = bus.src;
        if (bus.mask_we) m_mask = bus.mask_din;
        m_phase = nphase;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/int_req"}, 32'(bus.int_req), 32'(m_phase == 1));
        check({tag, "/pending"}, 32'(bus.pending_out), 32'(m_pend));
        check({tag, "/valid"},   32'(bus.active_valid), 32'(m_valid));
        check({tag, "/id"},      32'(bus.active_id), 32'(m_id));
        check({tag, "/spurious"},32'(bus.spurious), 32'(m_spur));
        check({tag, "/tmo_err"}, 32'(bus.timeout_err), 32'(m_terr));
    endtask

    // Apply one cycle of inputs (already at a negedge), clock it, then compare.
    task automatic step(input string tag, input logic [N-1:0] s, input logic we,
                        input logic [N-1:0] md, input logic a, input logic e);
        bus.src = s; bus.mask_we = we; bus.mask_din = md; bus.int_ack = a; bus.eoi = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        logic [N-1:0] s;
        bus.src = '0; bus.mask_we = 1'b0; bus.mask_din = '0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // Single source
        step("s1", 4'b0100, 0, 0, 0, 0);
        step("s1", 4'b0000, 0, 0, 0, 0);
        check("single_req", 32'(bus.int_req), 32'd1);
        step("s1ack", 4'b0000, 0, 0, 1, 0);
        check("single_id", 32'(bus.active_id), 32'd2);
        check("single_pend", 32'(bus.pending_out), 32'd0);
        step("s1eoi", 4'b0000, 0, 0, 0, 1);
        check("single_eoi_valid", 32'(bus.active_valid), 32'd0);

        // Priority
        step("p", 4'b1010, 0, 0, 0, 0);
        step("p", 4'b0000, 0, 0, 0, 0);
        step("pack", 4'b0000, 0, 0, 1, 0);
        check("prio_id1", 32'(bus.active_id), 32'd1);
        check("prio_pend", 32'(bus.pending_out), 32'b1000);
        step("peoi", 4'b0000, 0, 0, 0, 1);
        step("p", 4'b0000, 0, 0, 0, 0);
        check("prio_rereq", 32'(bus.int_req), 32'd1);
        step("pack2", 4'b0000, 0, 0, 1, 0);
        check("prio_id3", 32'(bus.active_id), 32'd3);
        step("peoi2", 4'b0000, 0, 0, 0, 1);

        // Mask
        step("m", 4'b0000, 1, 4'b0001, 0, 0);
        step("m", 4'b0001, 0, 0, 0, 0);
        step("m", 4'b0000, 0, 0, 0, 0);
        step("m", 4'b0000, 0, 0, 0, 0);
        check("mask_noreq", 32'(bus.int_req), 32'd0);
        check("mask_pend", 32'(bus.pending_out), 32'b0001);
        step("m", 4'b0000, 1, 4'b0000, 0, 0);
        step("m", 4'b0000, 0, 0, 0, 0);
        check("unmask_req", 32'(bus.int_req), 32'd1);
        step("m", 4'b0000, 0, 0, 1, 0);
        step("m", 4'b0000, 0, 0, 0, 1);

        // Spurious
        step("sp", 4'b0100, 0, 0, 0, 0);
        step("sp", 4'b0000, 0, 0, 0, 0);
        step("sp", 4'b0000, 1, 4'b0100, 0, 0);
        step("sp", 4'b0000, 0, 0, 1, 0);
        check("spur_flag", 32'(bus.spurious), 32'd1);
        check("spur_valid", 32'(bus.active_valid), 32'd0);
        check("spur_pend", 32'(bus.pending_out), 32'b0100);
        step("sp", 4'b0000, 0, 0, 0, 1);
        step("sp", 4'b0000, 1, 4'b0000, 0, 0);
        step("sp", 4'b0000, 0, 0, 0, 0);
        step("sp", 4'b0000, 0, 0, 1, 0);
        step("sp", 4'b0000, 0, 0, 0, 1);

        // Edge during service
        step("sv", 4'b0001, 0, 0, 0, 0);
        step("sv", 4'b0000, 0, 0, 0, 0);
        step("sv", 4'b0000, 0, 0, 1, 0);
        step("sv", 4'b0001, 0, 0, 0, 0);
        step("sv", 4'b0000, 0, 0, 1, 0);
        check("svc_pend", 32'(bus.pending_out), 32'b0001);
        check("svc_noreq", 32'(bus.int_req), 32'd0);
        step("sv", 4'b0000, 0, 0, 1, 1);
        step("sv", 4'b0000, 0, 0, 0, 0);
        check("svc_rereq", 32'(bus.int_req), 32'd1);
        step("sv", 4'b0000, 0, 0, 1, 1);
        step("sv", 4'b0000, 0, 0, 0, 1);

        // Long wait without ack (times out only when the counter is built)
        step("to", 4'b0010, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) step("to", 4'b0010, 0, 0, 0, 0);

        // Async reset in the middle of a request, source held high across release
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_req", 32'(bus.int_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rel", 4'b0010, 0, 0, 0, 0);
        step("rel", 4'b0010, 0, 0, 0, 0);
        check("rel_req", 32'(bus.int_req), 32'd1);

        // Randomized traffic
        s = '0;
        for (int k = 0; k < 1500; k++) begin
            s = s ^ (N'($urandom) & N'($urandom));
            step("rnd", s,
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt requester that drives the processor's `int` input.
- Collects edge-triggered requests from up to NUM_SRC peripherals, applies a mask, and raises a single request line toward the CPU.
- Captures the winning source ID when the CPU acknowledges (ISR entry) and holds it until the CPU signals end-of-interrupt (RTI retire).
- Sits between the peripherals and the top-level CPU; active_id is readable by the ISR through In_port.

Parameters:
NUM_SRC, 4, number of interrupt sources (2..8)
ID_W, 2, width of source ID; must equal ceil(log2(NUM_SRC))
ACK_TIMEOUT, 16, max cycles int_req may stay high without int_ack (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
src  in  NUM_SRC  peripheral request lines, synchronous to clk, rising-edge sensitive
mask_we  in  1  mask write strobe
mask_din  in  NUM_SRC  new mask value (1 = source disabled)
int_ack  in  1  one-cycle pulse: CPU has vectored to the ISR
eoi  in  1  one-cycle pulse: CPU retired RTI
int_req  out  1  interrupt request to the CPU `int` input
active_id  out  ID_W  ID of the source being serviced
active_valid  out  1  active_id holds a real serviced source
spurious  out  1  last ack found no eligible source
pending_out  out  NUM_SRC  current pending register
timeout_err  out  1  sticky ack-timeout flag (0 when feature is off)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pending, mask, src_q and active_id all 0.
  - int_req, active_valid, spurious and timeout_err all 0.
- Edge detect:
  - src_q <= src every cycle.
  - Edge = src & ~src_q. A source already high at reset release counts as one edge.
- Pending:
  - pending[i] is set on an edge of source i.
  - pending[i] is cleared when source i is selected on int_ack.
  - If the same bit is set and cleared in one cycle, set wins.
- Mask:
  - Loaded on mask_we; takes effect the next cycle.
  - Masking never clears pending bits.
- eligible = pending & ~mask. Priority: lowest index wins.
- FSM IDLE:
  - If |eligible, go to REQ next cycle. int_req is registered, so the first edge to int_req is 2 cycles.
  - int_ack and eoi are ignored.
- FSM REQ:
  - int_req=1.
  - On int_ack with |eligible: active_id = lowest eligible index, active_valid=1, spurious=0, clear that pending bit, go to SERVICE. int_req drops in the same cycle that SERVICE is entered.
  - On int_ack with eligible==0: spurious=1, active_valid=0, go to SERVICE.
  - No ack and eligible becomes 0 (masked meanwhile): return to IDLE, int_req=0.
- FSM SERVICE:
  - int_req=0; no nesting.
  - On eoi: active_valid=0, go to IDLE. Remaining eligible sources re-request 2 cycles after eoi.
  - int_ack is ignored.
  - New edges keep accumulating in pending.
- Simultaneous int_ack and eoi:
  - In REQ: ack is processed.
  - In SERVICE: eoi is processed.
- spurious holds until the next int_ack.
- Repeated edges on an already-pending source are merged (no count).

Optional Feature:
- Macro: IRQ_ACK_TIMEOUT_EN.
- When defined:
  - An 8-bit counter runs while the FSM is in REQ and clears on leaving REQ.
  - When the count reaches ACK_TIMEOUT with no int_ack: timeout_err=1 (sticky until reset), FSM returns to IDLE, int_req=0 for at least 1 cycle.
  - Pending is retained, so the request re-arms normally.
- When undefined:
  - No counter is built; REQ waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Single source: rst low then high, src=4'b0100 pulse → int_req=1 two cycles after the edge; int_ack pulse → active_id=2, active_valid=1, int_req=0, pending_out=0; eoi → active_valid=0, FSM IDLE.
- Priority: src=4'b1010 in the same cycle, ack → active_id=1, pending_out=4'b1000; eoi → int_req=1 again 2 cycles later; ack → active_id=3.
- Mask: mask_din=4'b0001 written, then src[0] edge → no int_req, pending_out=4'b0001; write mask=0 → int_req rises 2 cycles later.
- Spurious: src[2] edge, int_req=1, write mask=4'b0100 and pulse int_ack in the same cycle the mask takes effect → spurious=1, active_valid=0, pending_out=4'b0100 retained; eoi returns FSM to IDLE.
- Edge during service: while in SERVICE with id 0, src[0] pulses again → pending_out=4'b0001, int_req stays 0; eoi → int_req=1 two cycles later.
- Timeout (IRQ_ACK_TIMEOUT_EN, ACK_TIMEOUT=16): src[1] edge, never ack → after 16 cycles in REQ timeout_err=1, int_req low for ≥1 cycle, then re-asserted; async rst low mid-REQ clears int_req and timeout_err immediately.
